// File: rtl/alu_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc_pkg                                                           |
// | Shared types and helpers for the multicycle ALU: op encoding, FSM    |
// | state encoding and op-class decode helpers.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_DIV   = 4'd14,
    OP_REM   = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that would run on the iterative sequencer (MUL..REM).
  function automatic logic is_iter(op_e op);
    return (op >= OP_MUL);
  endfunction

  // Any divide/remainder op.
  function automatic logic is_div(op_e op);
    return (op >= OP_DIVU);
  endfunction

  // Remainder ops (REMU, REM) return the remainder instead of the quotient.
  function automatic logic is_rem(op_e op);
    return (op == OP_REMU) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_div(op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc_seq                                                           |
// | Iterative radix-2 multiply / restoring-divide datapath.              |
// |   clk, rst_n : clock, asynchronous active-low reset                  |
// |   start      : load operands and op (one-cycle pulse at accept)      |
// |   run        : iterate one bit this cycle                            |
// |   op, a, b   : op and raw operands, sampled on start                 |
// |   last       : this edge performs the final iteration                 |
// |   res        : final result incl. sign fix-up, valid while last      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_mc_seq
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH) + 1;

  // r_acc/r_lo form the 2*WIDTH working register: product high/low for
  // multiply, remainder/quotient (dividend shifted out MSB first) for divide.
  op_e              r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;

  logic             w_sgn;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_lo_nx;

  assign w_sgn   = is_signed_div(op);
  assign w_a_mag = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (w_sgn && b[WIDTH-1]) ? -b : b;

  always_comb begin
    w_madd   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_rsh    = {r_acc, r_lo[WIDTH-1]};
    w_diff   = w_rsh - {1'b0, r_opnd};
    w_acc_nx = r_acc;
    w_lo_nx  = r_lo;
    if (is_div(r_op)) begin
      // Restoring step: keep the trial difference only when it did not borrow.
      if (!w_diff[WIDTH]) begin
        w_acc_nx = w_diff[WIDTH-1:0];
        w_lo_nx  = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nx = w_rsh[WIDTH-1:0];
        w_lo_nx  = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add step: add multiplicand on multiplier LSB, shift right.
      w_acc_nx = w_madd[WIDTH:1];
      w_lo_nx  = {w_madd[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the value the last iteration produces, so the
  // top can register the final answer on that same edge.
  always_comb begin
    res = w_lo_nx;
    case (r_op)
      OP_MUL:          res = w_lo_nx;
      OP_MULHU:        res = w_acc_nx;
      OP_DIVU, OP_DIV: res = r_neg_q ? -w_lo_nx : w_lo_nx;
      OP_REMU, OP_REM: res = r_neg_r ? -w_acc_nx : w_acc_nx;
      default:         res = w_lo_nx;
    endcase
  end

  assign last = run && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_MUL;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      r_op  <= op;
      r_acc <= '0;
      r_cnt <= '0;
      if (is_div(op)) begin
        r_opnd  <= w_b_mag;
        r_lo    <= w_a_mag;
        r_neg_q <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r <= w_sgn && a[WIDTH-1];
      end else begin
        r_opnd  <= a;
        r_lo    <= b;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end
    end else if (run) begin
      r_acc <= w_acc_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc                                                               |
// | Multicycle RV32I/RV32M ALU with valid/ready handshakes. Simple ops   |
// | and divide special cases finish in one cycle; MUL/DIV/REM iterate.   |
// |   clk, rst_n          : clock, asynchronous active-low reset         |
// |   in_valid/in_ready   : operand handshake (ready only in IDLE)       |
// |   op, in_a, in_b      : op code and operands, captured at accept     |
// |   out_valid/out_ready : result handshake (valid held until ready)    |
// |   result, zero        : registered result and result==0 flag         |
// |   busy                : iterative op in flight                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nx;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  op_e              w_op;
  logic             w_accept;
  logic             w_start;
  logic             w_special;
  logic             w_b_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH-1:0] w_simple;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH:0]   w_sub_ext;
  logic             w_ovf;
  logic             w_slt;
  logic             w_sltu;
  logic [SHW-1:0]   w_shamt;
  logic             w_seq_last;
  logic [WIDTH-1:0] w_seq_res;
  logic             w_wr;
  logic [WIDTH-1:0] w_wr_val;

  assign w_op     = op_e'(op);
  assign w_accept = in_valid && (r_state == ST_IDLE);

  // a - b with carry out: carry clear means borrow (unsigned a < b).
  assign w_sub_ext = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
  assign w_ovf     = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (w_sub_ext[WIDTH-1] ^ in_a[WIDTH-1]);
  assign w_slt     = w_sub_ext[WIDTH-1] ^ w_ovf;
  assign w_sltu    = ~w_sub_ext[WIDTH];
  assign w_shamt   = in_b[SHW-1:0];

  always_comb begin
    w_simple = '0;
    case (w_op)
      OP_ADD:  w_simple = in_a + in_b;
      OP_SUB:  w_simple = w_sub_ext[WIDTH-1:0];
      OP_AND:  w_simple = in_a & in_b;
      OP_OR:   w_simple = in_a | in_b;
      OP_XOR:  w_simple = in_a ^ in_b;
      OP_SLT:  w_simple = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU: w_simple = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_SLL:  w_simple = in_a << w_shamt;
      OP_SRL:  w_simple = in_a >> w_shamt;
      OP_SRA:  w_simple = $unsigned($signed(in_a) >>> w_shamt);
      default: w_simple = '0;
    endcase
  end

  // Divide cases whose answer is known at accept and skip the sequencer.
  assign w_b_zero  = (in_b == '0);
  assign w_div_ovf = is_signed_div(w_op) && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_b);
  assign w_special = is_div(w_op) && (w_b_zero || w_div_ovf);

  always_comb begin
    if (w_b_zero) w_special_res = is_rem(w_op) ? in_a : '1;
    else          w_special_res = is_rem(w_op) ? '0 : in_a;
  end

  assign w_imm   = is_iter(w_op) ? w_special_res : w_simple;
  assign w_start = w_accept && is_iter(w_op) && !w_special;

  alu_mc_seq #(
    .WIDTH (WIDTH)
  ) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .run   (r_state == ST_BUSY),
    .op    (w_op),
    .a     (in_a),
    .b     (in_b),
    .last  (w_seq_last),
    .res   (w_seq_res)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nx = w_start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_seq_last) w_state_nx = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Result is written exactly once per op: at accept for one-cycle ops,
  // on the last iteration edge otherwise; it is held through DONE.
  assign w_wr     = (w_accept && !w_start) || w_seq_last;
  assign w_wr_val = w_seq_last ? w_seq_res : w_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_wr) begin
      r_result <= w_wr_val;
      r_zero   <= (w_wr_val == '0);
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_mc                                                            |
// | Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] result;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [3:0]  op8 = 4'd0;
  logic [7:0]  in_a8 = '0, in_b8 = '0;
  logic        in_ready8, out_valid8, zero8, busy8;
  logic [7:0]  result8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .in_a(in_a8), .in_b(in_b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op on the 32-bit unit (called at a negedge while idle),
  // scramble inputs after accept, wait for the result and consume it.
  task automatic run32(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bcnt;
    logic [31:0] res;
    logic z;
    in_valid = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; in_a = ~a; in_b = b ^ 32'h5a5a_a5a5;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!out_valid && lat < 200);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    res = result; z = zero;
    chk(tag, res, exp);
    chk({tag, "_zero"}, {31'd0, z}, {31'd0, exp == 32'd0});
    if (exp_lat > 0) begin
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_busy"}, bcnt, exp_lat - 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run8(input string tag, input logic [3:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
    int lat;
    in_valid8 = 1'b1; op8 = o; in_a8 = a; in_b8 = b;
    @(posedge clk); #1;
    in_valid8 = 1'b0; op8 = ~o; in_a8 = ~a; in_b8 = ~b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid8 && lat < 100);
    chk({tag, "_valid"}, {31'd0, out_valid8}, 32'd1);
    chk(tag, {24'd0, result8}, {24'd0, exp});
    chk({tag, "_zero"}, {31'd0, zero8}, {31'd0, exp == 8'd0});
    chk({tag, "_lat"}, lat, exp_lat);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_flags", {28'd0, in_ready, out_valid, busy, zero}, 32'h9);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One-cycle ops
    run32("add",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    run32("sub",   OP_SUB,  32'd5,         32'd5,         32'd0,         1);
    run32("xor",   OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    run32("slt",   OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    run32("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    run32("sra",   OP_SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1);
    run32("srl",   OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    run32("sll33", OP_SLL,  32'h0000_0003, 32'd33,        32'h0000_0006, 1);

    // Iterative ops: WIDTH+1 cycles, busy for WIDTH
    run32("mul",   OP_MUL,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
    run32("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33);
    run32("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run32("rem",   OP_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run32("divu",  OP_DIVU,  32'd100,       32'd7, 32'd14,        33);
    run32("remu",  OP_REMU,  32'd100,       32'd7, 32'd2,         33);

    // Divide special cases take the one-cycle path
    run32("divu00",  OP_DIVU, 32'd0,         32'd0,         32'hFFFF_FFFF, 1);
    run32("rem50",   OP_REM,  32'd5,         32'd0,         32'd5,         1);
    run32("divovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run32("removf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Back-pressure: result held, new requests ignored
    in_valid = 1'b1; op = OP_ADD; in_a = 32'd3; in_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = OP_SUB; in_a = 32'd100; in_b = 32'd1;
      @(negedge clk);
      chk("hold_result", result, 32'd7);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_idle", {30'd0, in_ready, out_valid}, 32'h2);
    chk("release_result", result, 32'd7);

    // Asynchronous reset in the middle of a divide
    in_valid = 1'b1; op = OP_DIVU; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", {28'd0, in_ready, out_valid, busy, zero}, 32'h9);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run32("post_rst_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

    // Narrow instance
    run8("w8_mul",   OP_MUL,   8'hFF, 8'hFF, 8'h01, 9);
    run8("w8_mulhu", OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 9);
    run8("w8_div",   OP_DIV,   8'hF9, 8'h02, 8'hFD, 9);
    run8("w8_rem",   OP_REM,   8'hF9, 8'h02, 8'hFF, 9);
    run8("w8_add",   OP_ADD,   8'h7F, 8'h01, 8'h80, 1);
    run8("w8_sll9",  OP_SLL,   8'h01, 8'd9,  8'h02, 1);
    run8("w8_divovf", OP_DIV,  8'h80, 8'hFF, 8'h80, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised multicycle ALU for the RV32 multicycle core, replacing the single-cycle ALU in the execute stage. It adds the full RV32I ALU op set (SLTU, SRA) and the RV32M multiply/divide subset. Simple ops complete in one cycle. MUL/DIV/REM run on an iterative radix-2 sequencer. Operands enter, and results leave, through valid/ready handshakes so the control FSM can stall on long ops.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept an op; high only in IDLE.
- op  in  4  operation code (alu_mc_pkg::op_e).
- in_a  in  WIDTH  operand A / dividend / multiplicand.
- in_b  in  WIDTH  operand B / divisor / multiplier.
- out_valid  out  1  result is valid; held until out_ready.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, registered with result.
- busy  out  1  high in BUSY.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
  - 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIVU, 13 REMU, 14 DIV, 15 REM.
- Accept when in_valid && in_ready. Op and operands are captured at accept; later input changes are ignored.
- FSM states are IDLE, BUSY, DONE.
  - IDLE→DONE for ops 0–9 and for divide special cases.
  - IDLE→BUSY for the remaining iterative ops.
  - BUSY→DONE when the iteration counter reaches WIDTH.
  - DONE→IDLE on out_ready.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT compares signed (sum sign XOR overflow); SLTU compares unsigned (borrow). Result is 0 or 1, zero-extended.
  - Shifts use in_b[SHW-1:0]. SRA replicates in_a[WIDTH-1].
- Multiply: shift-add over 2·WIDTH-bit product register, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle, on magnitudes. DIV/REM convert operands to magnitudes at accept, then negate at completion:
  - quotient negated if signs differ;
  - remainder takes dividend sign.
- Special cases, decided at accept, 1-cycle path:
  - in_b == 0: DIV/DIVU → all ones; REM/REMU → in_a.
  - DIV with in_a = −2^(WIDTH−1) and in_b = −1: quotient = in_a, REM = 0.
- zero is computed from the final result written into the result register.

## Timing
- Reset values:
  - state IDLE; in_ready 1; out_valid 0; busy 0.
  - result 0; zero 1; iteration counter 0.
- Accept at edge k:
  - ops 0–9 and special cases: out_valid = 1 after edge k+1.
  - iterative ops: busy = 1 from edge k+1 through edge k+WIDTH (WIDTH iterations). Sign fix-up is folded into the last iteration edge. out_valid = 1 after edge k+WIDTH+1.
- out_valid and result are stable until the cycle out_ready is seen high. State becomes IDLE on that edge; in_ready returns next cycle. Peak throughput is one simple op per 2 cycles.
- in_valid while in_ready = 0 is ignored; no stalling of in-flight ops.
- out_ready while out_valid = 0 has no effect.
- rst_n low at any time (including mid-BUSY) aborts immediately to reset values. No partial result is ever presented.

## Structure
- Package alu_mc_pkg holds:
  - op_e enum with the encoding above;
  - state_e (IDLE/BUSY/DONE);
  - helper is_iter(op) and is_signed_div(op).
- Sub-module alu_mc_seq (iterative multiply/divide datapath, counter, sign fix-up) is instantiated by alu_mc. The top holds the FSM, handshake and single-cycle ops.

## Test plan
- ADD 0x7FFFFFFF+1 → 0x80000000, out_valid 1 cycle after accept. SUB 5−5 → 0 with zero = 1.
- SLT 0xFFFFFFFF,1 → 1. SLTU same operands → 0. SRA 0x80000000 by 31 → 0xFFFFFFFF. SLL uses only in_b[4:0]: shift by 33 acts as shift by 1.
- MUL 0xFFFFFFFF×2 → 0xFFFFFFFE; MULHU same → 0x1. Latency is exactly WIDTH+1 cycles after accept, with busy high WIDTH cycles.
- DIV −7/2 → −3, REM → −1. DIVU 0/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000 in 1 cycle.
- Hold out_ready low 10 cycles: result stable, in_ready 0, a new in_valid is ignored. Then release: back in IDLE next cycle.
- Assert rst_n low mid-divide: outputs return to reset values asynchronously. Next op after reset gives a correct result.
- Repeat directed cases with WIDTH = 8 (MUL 0xFF×0xFF → 0x01, MULHU → 0xFE).
